// File: rtl/cordic_seq_controller_pkg.sv
// Shared types and helpers for the CORDIC sequencer: state encoding, mode
// codes and the iteration-count clamp.
package cordic_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  function automatic bit iters_out_of_range(input int n, input int max_iters);
    return (n == 0) || (n > max_iters);
  endfunction

  // Zero or oversize requests fall back to the full ROM depth.
  function automatic int clamp_iters(input int n, input int max_iters);
    return iters_out_of_range(n, max_iters) ? max_iters : n;
  endfunction

endpackage

// File: rtl/cordic_seq_controller_if.sv
// Handshake/control bundle between operand source, result consumer and the
// CORDIC sequencer.
interface cordic_seq_controller_if #(parameter int ITER_W = 5);
  logic              start;
  logic              mode_in;
  logic [ITER_W-1:0] num_iters;
  logic              abort;
  logic              out_ready;
  logic              in_ready;
  logic              load;
  logic              iter_en;
  logic [ITER_W-1:0] iter_idx;
  logic              mode;
  logic              out_valid;
  logic              busy;
  logic              cfg_err;
  logic              aborted;

  modport master (
    output start, mode_in, num_iters, abort, out_ready,
    input  in_ready, load, iter_en, iter_idx, mode, out_valid, busy, cfg_err, aborted
  );

  modport slave (
    input  start, mode_in, num_iters, abort, out_ready,
    output in_ready, load, iter_en, iter_idx, mode, out_valid, busy, cfg_err, aborted
  );
endinterface

// File: rtl/cordic_seq_controller_iter_counter.sv
// Micro-rotation counter: counts up while enabled and parks on limit-1
// instead of wrapping.
module cordic_iter_counter #(
  parameter int ITER_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic [ITER_W-1:0] limit,
  output logic [ITER_W-1:0] count,
  output logic              terminal
);
  assign terminal = (count == limit - ITER_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      count <= '0;
    else if (clear)                count <= '0;
    else if (enable && !terminal)  count <= count + ITER_W'(1);
  end
endmodule

// File: rtl/cordic_seq_controller.sv
// Sequencer for the iterative CORDIC datapath: handshakes operands in,
// steps N micro-rotations, and holds the result until the consumer takes it.
module cordic_seq_controller
  import cordic_ctrl_pkg::*;
#(
  parameter int MAX_ITERS = 16,
  parameter int ITER_W    = 5
) (
  input logic                    clk,
  input logic                    rst,
  cordic_seq_controller_if.slave bus
);
  state_t            state, state_nx;
  logic              mode_q;
  logic [ITER_W-1:0] n_q;
  logic [ITER_W-1:0] count;
  logic              terminal;
  logic              accept;
  logic              kill;
  logic              cfg_err_q;
  logic              aborted_q;

  assign bus.in_ready = (state == IDLE) || ((state == HOLD) && bus.out_ready);
  assign accept       = bus.start && bus.in_ready && !bus.abort;
  assign kill         = bus.abort && (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LOAD;
      LOAD:    state_nx = COMPUTE;
      COMPUTE: if (terminal) state_nx = HOLD;
      HOLD:    if (bus.out_ready) state_nx = accept ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
    // Abort outranks every other transition condition.
    if (kill) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q    <= MODE_ROT;
      n_q       <= ITER_W'(MAX_ITERS);
      cfg_err_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      cfg_err_q <= accept && iters_out_of_range(int'(bus.num_iters), MAX_ITERS);
      aborted_q <= kill;
      if (accept) begin
        mode_q <= bus.mode_in;
        n_q    <= ITER_W'(clamp_iters(int'(bus.num_iters), MAX_ITERS));
      end
    end
  end

  cordic_iter_counter #(.ITER_W(ITER_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state == LOAD) || kill),
    .enable   (state == COMPUTE),
    .limit    (n_q),
    .count    (count),
    .terminal (terminal)
  );

  // Counter parks on N-1 after HOLD; mask it so IDLE/LOAD read zero.
  assign bus.iter_idx  = ((state == COMPUTE) || (state == HOLD)) ? count : '0;
  assign bus.load      = (state == LOAD);
  assign bus.iter_en   = (state == COMPUTE);
  assign bus.out_valid = (state == HOLD);
  assign bus.busy      = (state != IDLE);
  assign bus.mode      = mode_q;
  assign bus.cfg_err   = cfg_err_q;
  assign bus.aborted   = aborted_q;
endmodule

// File: tb/tb_cordic_seq_controller.sv
// Directed bench for cordic_seq_controller: latency, clamping, back-pressure,
// back-to-back, abort and asynchronous reset.
module tb_cordic_seq_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  cordic_seq_controller_if #(.ITER_W(5)) bus();

  cordic_seq_controller #(.MAX_ITERS(16), .ITER_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"},      32'(bus.busy),      0);
    chk({tag, ".in_ready"},  32'(bus.in_ready),  1);
    chk({tag, ".load"},      32'(bus.load),      0);
    chk({tag, ".iter_en"},   32'(bus.iter_en),   0);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, ".iter_idx"},  32'(bus.iter_idx),  0);
  endtask

  // Entered in the LOAD cycle (start already dropped); leaves in HOLD.
  task automatic run_body(input string tag, input int n, input logic m, input logic cfg);
    chk({tag, ".load"},     32'(bus.load),     1);
    chk({tag, ".busy"},     32'(bus.busy),     1);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 0);
    chk({tag, ".cfg_err"},  32'(bus.cfg_err),  32'(cfg));
    chk({tag, ".mode"},     32'(bus.mode),     32'(m));
    chk({tag, ".idx_load"}, 32'(bus.iter_idx), 0);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, ".iter_en"},  32'(bus.iter_en),  1);
      chk({tag, ".iter_idx"}, 32'(bus.iter_idx), 32'(i));
      chk({tag, ".no_valid"}, 32'(bus.out_valid), 0);
      if (i == 0) chk({tag, ".cfg_err_pulse"}, 32'(bus.cfg_err), 0);
    end
    tick();
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 1);
    chk({tag, ".iter_en_off"}, 32'(bus.iter_en), 0);
    chk({tag, ".hold_idx"},  32'(bus.iter_idx),  32'(n - 1));
    chk({tag, ".hold_mode"}, 32'(bus.mode),      32'(m));
  endtask

  // Full operation from IDLE with out_ready=1, ending back in IDLE.
  task automatic run_op(input string tag, input logic m, input logic [4:0] req,
                        input int n, input logic cfg);
    bus.start = 1'b1; bus.mode_in = m; bus.num_iters = req; bus.out_ready = 1'b1;
    chk({tag, ".accept_rdy"}, 32'(bus.in_ready), 1);
    tick();
    bus.start = 1'b0;
    run_body(tag, n, m, cfg);
    tick();
    chk_idle({tag, ".end"});
  endtask

  initial begin
    bus.start = 1'b0; bus.mode_in = 1'b0; bus.num_iters = '0;
    bus.abort = 1'b0; bus.out_ready = 1'b0;
    #12;
    chk_idle("reset");
    chk("reset.mode",    32'(bus.mode),    0);
    chk("reset.cfg_err", 32'(bus.cfg_err), 0);
    chk("reset.aborted", 32'(bus.aborted), 0);
    tick();
    rst = 1'b1;
    tick();

    // Full-depth vectoring, then clamp cases and short counts.
    run_op("t1_n16",  1'b1, 5'd16, 16, 1'b0);
    run_op("t2_n0",   1'b0, 5'd0,  16, 1'b1);
    run_op("t2_n20",  1'b1, 5'd20, 16, 1'b1);
    run_op("t2_n5",   1'b0, 5'd5,  5,  1'b0);
    run_op("t2_n1",   1'b1, 5'd1,  1,  1'b0);
    run_op("t2_n31",  1'b0, 5'd31, 16, 1'b1);

    // Back-pressure in HOLD.
    bus.start = 1'b1; bus.mode_in = 1'b1; bus.num_iters = 5'd4; bus.out_ready = 1'b0;
    chk("t3.idle_rdy", 32'(bus.in_ready), 1);
    tick();
    bus.start = 1'b0;
    run_body("t3", 4, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 3);  // ignored while not ready
      tick();
      chk("t3.stall_valid", 32'(bus.out_valid), 1);
      chk("t3.stall_idx",   32'(bus.iter_idx),  3);
      chk("t3.stall_mode",  32'(bus.mode),      1);
      chk("t3.stall_rdy",   32'(bus.in_ready),  0);
    end
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("t3.rdy_comb", 32'(bus.in_ready), 1);
    tick();
    chk_idle("t3.end");

    // Back-to-back: accept from HOLD straight into LOAD.
    bus.start = 1'b1; bus.mode_in = 1'b1; bus.num_iters = 5'd3;
    tick();
    bus.start = 1'b0;
    run_body("t4a", 3, 1'b1, 1'b0);
    bus.start = 1'b1; bus.mode_in = 1'b0; bus.num_iters = 5'd3;
    chk("t4.hold_rdy", 32'(bus.in_ready), 1);
    tick();
    bus.start = 1'b0;
    run_body("t4b", 3, 1'b0, 1'b0);
    tick();
    chk_idle("t4.end");

    // Abort at iter_idx 7.
    bus.start = 1'b1; bus.mode_in = 1'b1; bus.num_iters = 5'd16;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("t5.idx7", 32'(bus.iter_idx), 7);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk_idle("t5.abort");
    chk("t5.aborted", 32'(bus.aborted), 1);
    tick();
    chk("t5.aborted_pulse", 32'(bus.aborted),   0);
    chk("t5.no_valid",      32'(bus.out_valid), 0);
    bus.start = 1'b1; bus.abort = 1'b1;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk_idle("t5.idle_abort");
    chk("t5.idle_no_pulse", 32'(bus.aborted), 0);
    tick();
    chk("t5.still_idle", 32'(bus.load), 0);

    // Asynchronous reset mid-COMPUTE.
    bus.start = 1'b1; bus.mode_in = 1'b1; bus.num_iters = 5'd10;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("t6.pre_idx", 32'(bus.iter_idx), 3);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("t6.async");
    chk("t6.mode",    32'(bus.mode),    0);
    chk("t6.aborted", 32'(bus.aborted), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("t6.aborted_after", 32'(bus.aborted), 0);
    run_op("t6_after", 1'b0, 5'd2, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
